// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: operand store and clear/feed/drain/capture sequencer for a 3x3 systolic array
module systolic_seq_ctrl #(
    parameter int CLEAR_CYCLES = 1,
    parameter int DRAIN_CYCLES = 5
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_wr_en,
    input  logic         i_wr_sel,
    input  logic [3:0]   i_wr_addr,
    input  logic [7:0]   i_wr_data,
    output logic         o_wr_err,
    input  logic         i_start,
    output logic         o_busy,
    output logic         o_arr_rst_n,
    output logic [7:0]   o_A1,
    output logic [7:0]   o_A2,
    output logic [7:0]   o_A3,
    output logic [7:0]   o_B1,
    output logic [7:0]   o_B2,
    output logic [7:0]   o_B3,
    input  logic [143:0] i_arr_C,
    output logic [143:0] o_C,
    output logic         o_c_valid,
    input  logic         i_c_ready
);
    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
    localparam logic [7:0] CLR_LAST = 8'(CLEAR_CYCLES - 1);
    localparam logic [7:0] DRN_LAST = 8'(DRAIN_CYCLES - 1);
    state_t state, next_state;
    logic [7:0] cnt, next_cnt;
    logic [7:0] a_mem [9];
    logic [7:0] b_mem [9];
    logic [3:0] kk, k3;
    logic feed, wr_ok;
    // state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end
    // next state, per-state cycle counter and feed column index
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = i_start ? CLEAR : IDLE;
            CLEAR:   next_state = (cnt == CLR_LAST) ? FEED : CLEAR;
            FEED:    next_state = (cnt == 8'd2) ? DRAIN : FEED;
            DRAIN:   next_state = (cnt == DRN_LAST) ? DONE : DRAIN;
            DONE:    next_state = (o_c_valid && i_c_ready) ? IDLE : DONE;
            default: next_state = IDLE;
        endcase
        next_cnt = (next_state != state || state == IDLE) ? 8'd0 : cnt + 8'd1;
        kk       = {2'b00, next_cnt[1:0]};
        k3       = kk + kk + kk;
        feed     = next_state == FEED;
        wr_ok    = i_wr_en && state == IDLE && i_wr_addr <= 4'd8;
    end
    // operand store, registered outputs computed from the upcoming state, result capture
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 9; i++) begin
                a_mem[i] <= '0;
                b_mem[i] <= '0;
            end
            o_wr_err    <= 1'b0;
            o_busy      <= 1'b0;
            o_arr_rst_n <= 1'b0;
            o_A1        <= '0;
            o_A2        <= '0;
            o_A3        <= '0;
            o_B1        <= '0;
            o_B2        <= '0;
            o_B3        <= '0;
            o_C         <= '0;
            o_c_valid   <= 1'b0;
        end else begin
            if (wr_ok && !i_wr_sel) a_mem[i_wr_addr] <= i_wr_data;
            if (wr_ok && i_wr_sel) b_mem[i_wr_addr] <= i_wr_data;
            o_wr_err    <= i_wr_en && !wr_ok;
            o_busy      <= next_state != IDLE;
            o_arr_rst_n <= next_state != CLEAR;
            o_A1        <= feed ? a_mem[kk] : 8'd0;
            o_A2        <= feed ? a_mem[4'd3 + kk] : 8'd0;
            o_A3        <= feed ? a_mem[4'd6 + kk] : 8'd0;
            o_B1        <= feed ? b_mem[k3] : 8'd0;
            o_B2        <= feed ? b_mem[k3 + 4'd1] : 8'd0;
            o_B3        <= feed ? b_mem[k3 + 4'd2] : 8'd0;
            if (state == DRAIN && next_state == DONE) begin
                o_C       <= i_arr_C;
                o_c_valid <= 1'b1;
            end else if (state == DONE && next_state == IDLE) begin
                o_c_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: directed and random runs against a matrix-product reference and a mock accumulating array
module tb_systolic_seq_ctrl;
    logic         i_clk, i_rst_n, i_wr_en, i_wr_sel, i_start, i_c_ready;
    logic [3:0]   i_wr_addr;
    logic [7:0]   i_wr_data;
    logic         o_wr_err, o_busy, o_arr_rst_n, o_c_valid;
    logic [7:0]   o_A1, o_A2, o_A3, o_B1, o_B2, o_B3;
    logic [143:0] i_arr_C, o_C, c_out;
    logic [15:0]  acc [3][3];
    logic [7:0]   fa [3];
    logic [7:0]   fb [3];
    int ma [9];
    int mb [9];
    int errors = 0;
    int checks = 0;

    systolic_seq_ctrl dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_en(i_wr_en), .i_wr_sel(i_wr_sel),
        .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .o_wr_err(o_wr_err), .i_start(i_start),
        .o_busy(o_busy), .o_arr_rst_n(o_arr_rst_n), .o_A1(o_A1), .o_A2(o_A2), .o_A3(o_A3),
        .o_B1(o_B1), .o_B2(o_B2), .o_B3(o_B3), .i_arr_C(i_arr_C), .o_C(o_C),
        .o_c_valid(o_c_valid), .i_c_ready(i_c_ready)
    );

    initial i_clk = 0;
    always #5 i_clk = ~i_clk;

    // mock array: each cell accumulates its row input times its column input, cleared while o_arr_rst_n low
    always_comb begin
        fa[0] = o_A1; fa[1] = o_A2; fa[2] = o_A3;
        fb[0] = o_B1; fb[1] = o_B2; fb[2] = o_B3;
        i_arr_C = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                i_arr_C[16*(3*i+j) +: 16] = acc[i][j];
    end
    always @(posedge i_clk)
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                acc[i][j] <= !o_arr_rst_n ? 16'd0 : acc[i][j] + 16'(fa[i]) * 16'(fb[j]);

    function automatic logic [143:0] matmul();
        logic [143:0] r = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                int s = 0;
                for (int k = 0; k < 3; k++) s += ma[3*i+k] * mb[3*k+j];
                r[16*(3*i+j) +: 16] = 16'(s);
            end
        return r;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_busy", o_busy, 0);
        chk("rst_arr_rst_n", o_arr_rst_n, 0);
        chk("rst_valid", o_c_valid, 0);
        chk("rst_wr_err", o_wr_err, 0);
        chk("rst_feeds", {o_A1, o_A2, o_A3, o_B1, o_B2, o_B3}, 0);
        chk("rst_C", o_C, 0);
    endtask

    task automatic wr(input bit sel, input int addr, input int data, input bit exp_err);
        i_wr_en = 1; i_wr_sel = sel; i_wr_addr = 4'(addr); i_wr_data = 8'(data);
        tick();
        i_wr_en = 0;
        chk("wr_err", o_wr_err, exp_err);
        if (!exp_err) begin
            if (sel) mb[addr] = data & 255;
            else ma[addr] = data & 255;
        end
    endtask

    task automatic load(input bit sel, input int base, input int step, input bit ident);
        for (int i = 0; i < 9; i++)
            wr(sel, i, ident ? ((i % 4 == 0) ? 1 : 0) : base + step * i, 0);
    endtask

    task automatic run(input int hold, input bit feed_wr, input bit start_wr);
        int n;
        logic [143:0] c_exp;
        if (start_wr) begin
            i_wr_en = 1; i_wr_sel = 0; i_wr_addr = 0; i_wr_data = 7; ma[0] = 7;
        end
        i_start = 1;
        tick();
        i_start = 0; i_wr_en = 0;
        n = 1;
        c_exp = matmul();
        chk("busy_start", o_busy, 1);
        if (start_wr) chk("start_wr_err", o_wr_err, 0);
        while (!o_c_valid && n < 40) begin
            chk("arr_rst_n", o_arr_rst_n, n == 1 ? 0 : 1);
            if (n >= 2 && n <= 4) begin
                int k = n - 2;
                chk("feed", {o_A1, o_A2, o_A3, o_B1, o_B2, o_B3},
                    {8'(ma[k]), 8'(ma[3+k]), 8'(ma[6+k]), 8'(mb[3*k]), 8'(mb[3*k+1]), 8'(mb[3*k+2])});
            end else begin
                chk("feed_zero", {o_A1, o_A2, o_A3, o_B1, o_B2, o_B3}, 0);
            end
            if (feed_wr && n == 3) begin
                i_wr_en = 1; i_wr_sel = 0; i_wr_addr = 0; i_wr_data = 99;
            end
            tick();
            n++;
            if (feed_wr && n == 4) begin
                chk("feed_wr_err", o_wr_err, 1);
                i_wr_en = 0;
            end
        end
        chk("latency", n, 10);
        chk("valid", o_c_valid, 1);
        chk("result", o_C, c_exp);
        c_out = o_C;
        i_start = 1;
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_valid", o_c_valid, 1);
            chk("hold_busy", o_busy, 1);
            chk("hold_C", o_C, c_exp);
        end
        i_c_ready = 1;
        tick();
        i_c_ready = 0; i_start = 0;
        chk("hs_valid", o_c_valid, 0);
        chk("hs_busy", o_busy, 0);
    endtask

    initial begin
        i_rst_n = 1; i_wr_en = 0; i_wr_sel = 0; i_wr_addr = 0; i_wr_data = 0;
        i_start = 0; i_c_ready = 0;
        for (int i = 0; i < 9; i++) begin ma[i] = 0; mb[i] = 0; end
        #3 i_rst_n = 0;
        #1 chk_reset_vals();
        tick(); tick();
        i_rst_n = 1;
        tick();
        chk("idle_arr_rst_n", o_arr_rst_n, 1);
        chk("idle_busy", o_busy, 0);
        // identity times 1..9
        load(0, 0, 0, 1);
        load(1, 1, 1, 0);
        run(0, 0, 0);
        chk("t1_C_eq_B", c_out, {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1});
        // all-255 operands wrap modulo 2^16
        load(0, 255, 0, 0);
        load(1, 255, 0, 0);
        run(0, 0, 0);
        chk("t2_fa03", c_out, {9{16'hFA03}});
        // 1..9 times 9..1 with a long backpressure hold
        load(0, 1, 1, 0);
        load(1, 9, -1, 0);
        run(20, 0, 0);
        chk("t3_C", c_out, {16'd90, 16'd114, 16'd138, 16'd54, 16'd69, 16'd84, 16'd18, 16'd24, 16'd30});
        // rejected writes: bad address in idle, any write during feed
        load(0, 0, 0, 1);
        load(1, 1, 1, 0);
        wr(0, 9, 55, 1);
        run(2, 1, 0);
        chk("t4_C_eq_B", c_out, {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1});
        // reset in the middle of drain
        i_start = 1;
        tick();
        i_start = 0;
        repeat (6) tick();
        chk("t5_busy_drain", o_busy, 1);
        i_rst_n = 0;
        #1 chk_reset_vals();
        tick();
        i_rst_n = 1;
        for (int i = 0; i < 9; i++) begin ma[i] = 0; mb[i] = 0; end
        tick();
        run(0, 0, 0);
        chk("t5_cleared_store", c_out, 0);
        load(0, 0, 0, 1);
        load(1, 1, 1, 0);
        run(1, 0, 0);
        chk("t5_rerun", c_out, {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1});
        // write and start in the same cycle
        run(0, 0, 1);
        chk("t6_row0", c_out[47:0], {16'd21, 16'd14, 16'd7});
        // random operands and random backpressure
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 9; i++) wr(0, i, int'($urandom_range(0, 255)), 0);
            for (int i = 0; i < 9; i++) wr(1, i, int'($urandom_range(0, 255)), 0);
            run(int'($urandom_range(0, 4)), 0, 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
